// File: rtl/conv_tap_sequencer.sv
// conv_tap_sequencer: steps a 9-to-1 tap mux through a 3x3 window and accumulates signed coefficient weights
module conv_tap_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [35:0] coef,
  input  logic        mux_in,
  output logic [3:0]  sel,
  output logic        busy,
  output logic [7:0]  result,
  output logic        result_valid,
  input  logic        result_ready
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
  state_t      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  result_q, result_d;
  logic [35:0] coef_q, coef_d;
  logic [3:0]  tap_idx;
  logic [3:0]  tap_coef;
  logic [7:0]  sum;
  // next-state and datapath: pick the current tap's latched weight and add it when the mux reports a 1
  always_comb begin
    tap_idx  = sel_q - 4'd1;
    tap_coef = coef_q[{tap_idx, 2'b00} +: 4];
    sum      = acc_q + (mux_in ? {{4{tap_coef[3]}}, tap_coef} : 8'd0);
    state_d  = state_q;
    sel_d    = sel_q;
    busy_d   = busy_q;
    valid_d  = valid_q;
    acc_d    = acc_q;
    result_d = result_q;
    coef_d   = coef_q;
    case (state_q)
      IDLE: if (start) begin
        coef_d  = coef;
        acc_d   = 8'd0;
        sel_d   = 4'd1;
        busy_d  = 1'b1;
        state_d = RUN;
      end
      RUN: if (sel_q == 4'd9) begin
        result_d = sum;
        valid_d  = 1'b1;
        sel_d    = 4'd0;
        state_d  = HOLD;
      end else begin
        acc_d = sum;
        sel_d = sel_q + 4'd1;
      end
      HOLD: if (result_ready) begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        sel_d   = 4'd0;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end
  // state and registered outputs; reset drops any partial window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= 4'd0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      acc_q    <= 8'd0;
      result_q <= 8'd0;
      coef_q   <= 36'd0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      coef_q   <= coef_d;
    end
  end
  assign sel          = sel_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = valid_q;
endmodule

// File: tb/tb_conv_tap_sequencer.sv
// tb_conv_tap_sequencer: randomized windows checked against a plain-arithmetic weighted-sum model
module tb_conv_tap_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [35:0] coef = 36'd0;
  logic        mux_in;
  logic [3:0]  sel;
  logic        busy;
  logic [7:0]  result;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic [8:0]  mask = 9'd0;
  int          vectors = 0;
  int          miscompares = 0;

  conv_tap_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .coef(coef), .mux_in(mux_in),
    .sel(sel), .busy(busy), .result(result), .result_valid(result_valid),
    .result_ready(result_ready)
  );

  always #5 clk = ~clk;

  // the bench plays the 9-to-1 tap mux: bit k-1 of mask is the pixel under tap k
  assign mux_in = (sel >= 4'd1 && sel <= 4'd9) ? mask[sel - 4'd1] : 1'b0;

  function automatic logic [7:0] ref_sum(input logic [35:0] c, input logic [8:0] m);
    int s = 0;
    for (int k = 0; k < 9; k++) begin
      int v = int'(c[4*k +: 4]);
      if (v > 7) v -= 16;
      if (m[k]) s += v;
    end
    return s[7:0];
  endfunction

  task automatic run_window(input logic [35:0] c, input logic [8:0] m, input int hold, input bit scramble);
    logic [7:0] exp;
    exp = ref_sum(c, m);
    mask = m;
    coef = c;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      vectors++;
      if (sel !== i[3:0] || busy !== 1'b1 || result_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL run_step%0d: sel=%0d busy=%b valid=%b, want sel=%0d busy=1 valid=0", i, sel, busy, result_valid, i);
      end
      if (scramble) begin
        coef = {$urandom, $urandom};
        start = 1'($urandom);
        result_ready = 1'($urandom);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    result_ready = 1'b0;
    vectors++;
    if (result_valid !== 1'b1 || result !== exp || sel !== 4'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL done: valid=%b result=%h sel=%0d busy=%b, want valid=1 result=%h sel=0 busy=1", result_valid, result, sel, busy, exp);
    end
    for (int h = 0; h < hold; h++) begin
      start = 1'($urandom);
      @(posedge clk); #1;
      vectors++;
      if (result_valid !== 1'b1 || result !== exp || sel !== 4'd0 || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL hold%0d: valid=%b result=%h sel=%0d busy=%b, want valid=1 result=%h sel=0 busy=1", h, result_valid, result, sel, busy, exp);
      end
    end
    start = 1'b1;
    result_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    result_ready = 1'b0;
    vectors++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || sel !== 4'd0 || result !== exp) begin
      miscompares++;
      $display("FAIL release: valid=%b busy=%b sel=%0d result=%h, want valid=0 busy=0 sel=0 result=%h", result_valid, busy, sel, result, exp);
    end
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || sel !== 4'd0 || result !== exp) begin
      miscompares++;
      $display("FAIL idle_after: busy=%b sel=%0d result=%h, want busy=0 sel=0 result=%h", busy, sel, result, exp);
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (sel !== 4'd0 || busy !== 1'b0 || result !== 8'd0 || result_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: sel=%0d busy=%b result=%h valid=%b, want all 0", sel, busy, result, result_valid);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_all_ones;
    run_window(36'h111111111, 9'h1FF, 1, 1'b0);
    vectors++;
    if (result !== 8'h09) begin
      miscompares++;
      $display("FAIL all_ones: result=%h, want 09", result);
    end
  endtask

  task automatic test_extremes;
    run_window(36'h888888888, 9'h1FF, 0, 1'b0);
    vectors++;
    if (result !== 8'hB8) begin
      miscompares++;
      $display("FAIL all_minus8: result=%h, want b8", result);
    end
    run_window(36'h777777777, 9'h1FF, 0, 1'b0);
    vectors++;
    if (result !== 8'h3F) begin
      miscompares++;
      $display("FAIL all_plus7: result=%h, want 3f", result);
    end
  endtask

  task automatic test_single_tap;
    run_window(36'h000070000, 9'b000010000, 0, 1'b0);
    vectors++;
    if (result !== 8'h07) begin
      miscompares++;
      $display("FAIL tap5_plus7: result=%h, want 07", result);
    end
    run_window(36'h0000D0000, 9'b000010000, 0, 1'b0);
    vectors++;
    if (result !== 8'hFD) begin
      miscompares++;
      $display("FAIL tap5_minus3: result=%h, want fd", result);
    end
  endtask

  task automatic test_hold_stall;
    run_window({$urandom, $urandom}, 9'($urandom), 5, 1'b1);
  endtask

  task automatic test_random;
    for (int n = 0; n < 25; n++)
      run_window({$urandom, $urandom}, 9'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
  endtask

  task automatic test_reset_mid_run;
    mask = 9'h1FF;
    coef = 36'h777777777;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (sel !== 4'd4 || result === 8'd0) begin
      miscompares++;
      $display("FAIL pre_reset: sel=%0d result=%h, want sel=4 result nonzero", sel, result);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (sel !== 4'd0 || busy !== 1'b0 || result !== 8'd0 || result_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: sel=%0d busy=%b result=%h valid=%b, want all 0", sel, busy, result, result_valid);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      vectors++;
      if (result_valid !== 1'b0 || busy !== 1'b0 || sel !== 4'd0) begin
        miscompares++;
        $display("FAIL post_reset%0d: valid=%b busy=%b sel=%0d, want 0 0 0", i, result_valid, busy, sel);
      end
    end
    run_window({$urandom, $urandom}, 9'($urandom), 1, 1'b0);
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 5; n++)
      run_window({$urandom, $urandom}, 9'($urandom), 0, 1'b1);
  endtask

  initial begin
    test_reset;
    test_all_ones;
    test_extremes;
    test_single_tap;
    test_hold_stall;
    test_random;
    test_reset_mid_run;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
